ext_pulse_gen: RTL and testbench
================================

// Module: ext_pulse_gen
// PURPOSE
//  Stimulus source for the external edge counter path: drives a glitch-free, registered
//  pulse train on pin D15 with a programmable count and high/low times. A start/busy/done
//  handshake controls it. Looping D15 to the counter input (D16) on the board gives a
//  self-test of edge detection, with the counter reading equal to sent_count.
// PARAMETERS
//  CNT_W  16  width of pulse_count / sent_count
//  PER_W  16  width of high_cycles / low_cycles (clock cycles per phase)
// PORTS
//  CLK_IN       in   1      system clock; all logic on posedge
//  RST_N_IN     in   1      reset, asynchronous, active-low
//  start        in   1      request a burst; sampled only in IDLE
//  stop         in   1      level; finish current pulse, then end the burst early
//  pulse_count  in   CNT_W  number of pulses in the burst; latched at start
//  high_cycles  in   PER_W  high phase length; latched at start; 0 treated as 1
//  low_cycles   in   PER_W  low phase length; latched at start; 0 treated as 1
//  D15_o        out  1      pulse output pin, driven directly from a flop
//  busy         out  1      high from the cycle after start until the cycle done is high
//  done         out  1      single-cycle strobe when the burst ends
//  sent_count   out  CNT_W  rising edges emitted in the current/last burst
// BEHAVIOUR
//  Reset (async, RST_N_IN=0): state=IDLE, D15_o=0, busy=0, done=0, sent_count=0, phase timer=0.
//  Reset mid-burst drops D15_o low immediately. No pending pulse is resumed after reset.
//  States: IDLE -> HIGH -> LOW -> (HIGH | IDLE).
//  IDLE: start=1 at edge T latches the config and clears sent_count.
//    pulse_count!=0: at T+1 state=HIGH, D15_o=1, busy=1, sent_count=1.
//    pulse_count==0: at T+1 done=1; busy stays 0; D15_o stays 0; sent_count=0.
//  HIGH: D15_o=1 for exactly H=max(high_cycles,1) cycles, then LOW.
//  LOW: D15_o=0 for exactly L=max(low_cycles,1) cycles. At the end of the LOW phase:
//    sent_count==latched count, or stop=1 -> IDLE, with done=1 and busy=0 on that same cycle.
//    otherwise -> HIGH and sent_count+1 (increment coincides with the D15_o rising edge).
//  Period = H+L cycles. The minimum period is 2 cycles (1 high, 1 low).
//  Every burst ends with a full LOW phase. The last pulse is never truncated.
//  stop is sampled only at the end of a LOW phase. stop in IDLE has no effect.
//  start while not IDLE is ignored. Input changes after latch are ignored.
//  start=1 on the done cycle is ignored. A new burst needs start in IDLE, earliest 1 cycle
//  after done.
//  Counters never wrap: sent_count <= pulse_count <= 2^CNT_W-1.
//  Phase timer: PER_W bits, loads H-1 / L-1, counts down to 0.
// CONFIGURATION
//  EXT_PULSE_GEN_LED_EN defined: adds ports LED_D9..LED_D2 (out, 1 each).
//    {LED_D9..LED_D2} = sent_count[7:0], registered, reset 0.
//    This shows the same byte as the counter LEDs for visual comparison.
//  Undefined: no LED ports and no extra logic. All other behaviour is identical.
// STRUCTURE
//  Shared package/include ext_io_defs: state encoding localparams
//    (ST_IDLE=2'd0, ST_HIGH=2'd1, ST_LOW=2'd2) and the CNT_W/PER_W defaults.
//    These are shared with the counter block.
//  Single module. The phase down-counter is inline; no sub-module is warranted.
// TESTING
//  1 count=3,H=2,L=3,start@T -> D15_o high T+1..T+2, T+6..T+7, T+11..T+12; done@T+15; sent_count=3.
//  2 count=0, start -> done one cycle later; D15_o never high; busy never high.
//  3 H=0,L=0,count=4 -> treated as 1/1; D15_o toggles every cycle for 8 cycles; done once.
//  4 count=10,H=L=1, stop=1 during the 2nd pulse -> burst ends after the 2nd LOW; sent_count=2.
//  5 RST_N_IN=0 during HIGH of a count=5 burst -> D15_o=0 async; all outputs 0; start then
//    runs a fresh burst correctly.
//  6 Loopback D15_o->counter, count=300,H=3,L=5 -> counter advances 300 (LSB byte 0x2C);
//    a start pulse while busy leaves the burst unchanged.

Source files
------------

// File: rtl/ext_io_defs.sv
// Shared definitions for the external edge I/O blocks (pulse generator and edge counter).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ext_io_defs;

    // Default widths for burst counts and phase lengths.
    localparam int CNT_W_DEF = 16;
    localparam int PER_W_DEF = 16;

    // State encoding shared with the counter block; 2'd3 is unused.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } ext_state_t;

endpackage

// File: rtl/ext_pulse_gen.sv
// Glitch-free registered pulse-train source on pin D15 with programmable count and high/low times.
// Latency: first rising edge of D15_o one cycle after start is sampled in IDLE.
// Backpressure: none; start is ignored unless idle, stop ends the burst after the current pulse.
//
// Ports:
//   CLK_IN, RST_N_IN         clock (posedge) and asynchronous active-low reset
//   start / stop             burst request (idle only) / early-finish level
//   pulse_count              pulses per burst, latched at start
//   high_cycles, low_cycles  phase lengths in cycles, latched at start, 0 behaves as 1
//   D15_o                    pulse pin, straight from a flop
//   busy / done              burst in progress / one-cycle end-of-burst strobe
//   sent_count               rising edges emitted in the current or last burst
//   LED_D9..LED_D2           only with EXT_PULSE_GEN_LED_EN: registered copy of sent_count[7:0]
module ext_pulse_gen
    import ext_io_defs::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PER_W = PER_W_DEF
) (
    input  logic             CLK_IN,
    input  logic             RST_N_IN,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] pulse_count,
    input  logic [PER_W-1:0] high_cycles,
    input  logic [PER_W-1:0] low_cycles,
    output logic             D15_o,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent_count
`ifdef EXT_PULSE_GEN_LED_EN
    ,
    output logic             LED_D9,
    output logic             LED_D8,
    output logic             LED_D7,
    output logic             LED_D6,
    output logic             LED_D5,
    output logic             LED_D4,
    output logic             LED_D3,
    output logic             LED_D2
`endif
);

    localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    ext_state_t       state;
    logic [PER_W-1:0] timer;
    logic [PER_W-1:0] high_m1;
    logic [PER_W-1:0] low_m1;
    logic [CNT_W-1:0] cnt_q;
    logic             finish;

    // Phase length minus one, with a zero length behaving as one cycle.
    function automatic logic [PER_W-1:0] phase_m1(input logic [PER_W-1:0] len);
        return (len == '0) ? '0 : len - PER_ONE;
    endfunction

    // The burst ends when all pulses are out or stop is requested. The decision is
    // taken on the edge that enters the final LOW cycle, so that cycle doubles as
    // the done cycle (state already IDLE, busy low) and the LOW phase keeps full length.
    assign finish = (sent_count == cnt_q) || stop;

    always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) begin
            state      <= ST_IDLE;
            timer      <= '0;
            high_m1    <= '0;
            low_m1     <= '0;
            cnt_q      <= '0;
            D15_o      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sent_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A start on the done cycle is dropped.
                    if (start && !done) begin
                        cnt_q   <= pulse_count;
                        high_m1 <= phase_m1(high_cycles);
                        low_m1  <= phase_m1(low_cycles);
                        if (pulse_count == '0) begin
                            sent_count <= '0;
                            done       <= 1'b1;
                        end else begin
                            state      <= ST_HIGH;
                            timer      <= phase_m1(high_cycles);
                            D15_o      <= 1'b1;
                            busy       <= 1'b1;
                            sent_count <= CNT_ONE;
                        end
                    end
                end
                ST_HIGH: begin
                    if (timer != '0) begin
                        timer <= timer - PER_ONE;
                    end else if ((low_m1 == '0) && finish) begin
                        // Single-cycle LOW phase: it is itself the done cycle.
                        state <= ST_IDLE;
                        D15_o <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= ST_LOW;
                        timer <= low_m1;
                        D15_o <= 1'b0;
                    end
                end
                ST_LOW: begin
                    if (timer == '0) begin
                        state      <= ST_HIGH;
                        timer      <= high_m1;
                        D15_o      <= 1'b1;
                        sent_count <= sent_count + CNT_ONE;
                    end else if ((timer == PER_ONE) && finish) begin
                        state <= ST_IDLE;
                        timer <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        timer <= timer - PER_ONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    timer <= '0;
                    D15_o <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef EXT_PULSE_GEN_LED_EN
    logic [7:0] led_q;

    always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) begin
            led_q <= '0;
        end else begin
            led_q <= sent_count[7:0];
        end
    end

    assign {LED_D9, LED_D8, LED_D7, LED_D6, LED_D5, LED_D4, LED_D3, LED_D2} = led_q;
`endif

endmodule

// File: tb/tb_ext_pulse_gen.sv
// Bench for ext_pulse_gen: per-burst expected waveform derived from period arithmetic.
// Latency: n/a.
// Backpressure: n/a.
module tb_ext_pulse_gen;

    logic        CLK_IN = 1'b0;
    logic        RST_N_IN;
    logic        start;
    logic        stop;
    logic [15:0] pulse_count;
    logic [15:0] high_cycles;
    logic [15:0] low_cycles;
    logic        D15_o;
    logic        busy;
    logic        done;
    logic [15:0] sent_count;

    int n_checks = 0;
    int n_errors = 0;
    int burst_id = 0;

    ext_pulse_gen dut (
        .CLK_IN      (CLK_IN),
        .RST_N_IN    (RST_N_IN),
        .start       (start),
        .stop        (stop),
        .pulse_count (pulse_count),
        .high_cycles (high_cycles),
        .low_cycles  (low_cycles),
        .D15_o       (D15_o),
        .busy        (busy),
        .done        (done),
        .sent_count  (sent_count)
    );

    always #5 CLK_IN = ~CLK_IN;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one burst starting from a point #1 after a rising edge. Cycle 0 is the
    // start cycle. The expected waveform comes from period arithmetic: pulse k
    // begins at 1+(k-1)*P, its last LOW cycle (and possible done cycle) is at
    // 1+k*P-1, and stop is honoured when high in the cycle just before that.
    // stop_at >= 0 places a single stop cycle; otherwise stop is random at stop_pct.
    task automatic run_burst(input int n, input int h, input int l, input int stop_pct,
                             input int stop_at, input bit noise,
                             output int obs_done_t, output logic [31:0] obs_mask,
                             output int obs_edges, output int obs_sent);
        int he, le, p, end_t, kend, s, es;
        bit stopv[];
        bit prev_d15;
        logic e_d15, e_busy, e_done;

        burst_id++;
        he = (h == 0) ? 1 : h;
        le = (l == 0) ? 1 : l;
        p  = he + le;
        stopv = new[n * p + 4];
        foreach (stopv[j]) begin
            if (stop_at >= 0) stopv[j] = (j == stop_at);
            else              stopv[j] = (int'($urandom_range(99)) < stop_pct);
        end

        end_t = 1;
        kend  = 0;
        for (int k = 1; k <= n; k++) begin
            s = 1 + (k - 1) * p;
            if (k == n || stopv[s + p - 2]) begin
                end_t = s + p - 1;
                kend  = k;
                break;
            end
        end

        start       = 1'b1;
        stop        = stopv[0];
        pulse_count = 16'(n);
        high_cycles = 16'(h);
        low_cycles  = 16'(l);

        obs_done_t = -1;
        obs_mask   = '0;
        obs_edges  = 0;
        prev_d15   = 1'b0;

        for (int t = 1; t <= end_t + 2; t++) begin
            @(posedge CLK_IN);
            #1;
            if (t <= end_t) begin
                e_d15  = (n != 0) && (((t - 1) % p) < he);
                e_busy = (n != 0) && (t < end_t);
                e_done = (t == end_t);
                es     = (n == 0) ? 0 : ((t - 1) / p + 1);
            end else begin
                e_d15  = 1'b0;
                e_busy = 1'b0;
                e_done = 1'b0;
                es     = kend;
            end
            check($sformatf("burst%0d t=%0d {d15,busy,done,sent}", burst_id, t),
                  {13'b0, D15_o, busy, done, sent_count},
                  {13'b0, e_d15, e_busy, e_done, 16'(es)});
            if (done && obs_done_t < 0) obs_done_t = t;
            if (t < 32 && D15_o) obs_mask[t] = 1'b1;
            if (D15_o && !prev_d15) obs_edges++;
            prev_d15 = D15_o;

            // Inputs for cycle t: spurious starts while busy or on the done cycle,
            // and config churn after the latch, must all be ignored.
            start = noise && (t <= end_t) && ($urandom_range(2) == 0);
            stop  = (t < stopv.size()) ? stopv[t] : 1'b0;
            if (noise) begin
                pulse_count = 16'($urandom_range(20));
                high_cycles = 16'($urandom_range(6));
                low_cycles  = 16'($urandom_range(6));
            end
        end
        start    = 1'b0;
        stop     = 1'b0;
        obs_sent = int'(sent_count);
    endtask

    int          d_t, edges, sent;
    logic [31:0] mask;

    initial begin
        RST_N_IN    = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        pulse_count = '0;
        high_cycles = '0;
        low_cycles  = '0;
        repeat (3) @(posedge CLK_IN);
        #1;
        check("reset outputs", {13'b0, D15_o, busy, done, sent_count}, 32'd0);
        RST_N_IN = 1'b1;
        @(posedge CLK_IN);
        #1;

        // count=3, H=2, L=3: highs at 1-2, 6-7, 11-12, done at 15.
        run_burst(3, 2, 3, 0, -1, 1'b0, d_t, mask, edges, sent);
        check("t1 done time", 32'(d_t), 32'd15);
        check("t1 high mask", mask, 32'd6342);
        check("t1 sent", 32'(sent), 32'd3);

        // count=0: done one cycle later, no pulse, busy never (checked per cycle).
        run_burst(0, 4, 4, 0, -1, 1'b1, d_t, mask, edges, sent);
        check("t2 done time", 32'(d_t), 32'd1);
        check("t2 high mask", mask, 32'd0);

        // H=L=0 behaves as 1/1: toggles every cycle for 8 cycles.
        run_burst(4, 0, 0, 0, -1, 1'b0, d_t, mask, edges, sent);
        check("t3 done time", 32'(d_t), 32'd8);
        check("t3 high mask", mask, 32'd170);

        // stop during the 2nd pulse of a count=10 burst.
        run_burst(10, 1, 1, 0, 3, 1'b0, d_t, mask, edges, sent);
        check("t4 sent", 32'(sent), 32'd2);
        check("t4 done time", 32'(d_t), 32'd4);

        // Asynchronous reset during the HIGH phase of a count=5 burst.
        start       = 1'b1;
        pulse_count = 16'd5;
        high_cycles = 16'd3;
        low_cycles  = 16'd2;
        @(posedge CLK_IN);
        #1;
        start = 1'b0;
        @(posedge CLK_IN);
        #1;
        check("t5 high before reset", {31'b0, D15_o}, 32'd1);
        #3;
        RST_N_IN = 1'b0;
        #1;
        check("t5 async reset", {13'b0, D15_o, busy, done, sent_count}, 32'd0);
        @(posedge CLK_IN);
        #1;
        check("t5 held in reset", {13'b0, D15_o, busy, done, sent_count}, 32'd0);
        RST_N_IN = 1'b1;
        repeat (2) @(posedge CLK_IN);
        #1;
        check("t5 no resume", {13'b0, D15_o, busy, done, sent_count}, 32'd0);
        run_burst(5, 3, 2, 0, -1, 1'b0, d_t, mask, edges, sent);
        check("t5 fresh sent", 32'(sent), 32'd5);
        check("t5 fresh done time", 32'(d_t), 32'd25);

        // Loopback-style edge count with spurious starts during the burst.
        run_burst(300, 3, 5, 0, -1, 1'b1, d_t, mask, edges, sent);
        check("t6 edges", 32'(edges), 32'd300);
        check("t6 lsb byte", 32'(sent & 8'hFF), 32'h2C);
        check("t6 done time", 32'(d_t), 32'd2400);

        // Randomized bursts with random stop and input churn.
        for (int i = 0; i < 20; i++) begin
            run_burst(int'($urandom_range(12)), int'($urandom_range(4)),
                      int'($urandom_range(4)), 8, -1, 1'b1, d_t, mask, edges, sent);
            repeat ($urandom_range(2)) @(posedge CLK_IN);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
